inst_seq_ctrl: RTL and testbench
================================

Name: inst_seq_ctrl

Overview:
- Program-counter sequencer for the instruction memory.
- Owns the PC, runs the start/run/done lifecycle and issues one instruction per accepted beat to the datapath over a valid/ready handshake.
- Gates the loop-control block (enable/stall/debug) and applies its jump and loop-done decisions.
- Provides debug halt/single-step and status counters to the CSR file.

Parameters:
- InstMemAddrWidth, 32, PC / instruction address width
- CycleCountWidth, 32, width of the issued-instruction counter
- LoopNumWidth, 3, width of the loop-mode field (0 = loops disabled)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- start_i  in  1  pulse: start program at address 0
- clr_i  in  1  synchronous clear; same effect as reset
- dbg_en_i  in  1  debug halt request
- dbg_step_i  in  1  pulse: issue exactly one instruction while halted
- inst_loop_mode_i  in  LoopNumWidth  loop mode from CSR
- inst_last_addr_i  in  InstMemAddrWidth  last program address, used when loops are disabled
- inst_jump_i  in  1  jump request from loop control
- inst_jump_addr_i  in  InstMemAddrWidth  jump target
- inst_loop_done_i  in  1  outermost loop finished at current PC
- inst_ready_i  in  1  datapath accepts current instruction
- inst_pc_o  out  InstMemAddrWidth  current PC / memory read address
- inst_valid_o  out  1  instruction at inst_pc_o is issued
- loop_en_o  out  1  enable to loop control
- loop_stall_o  out  1  stall to loop control
- loop_clr_o  out  1  clear to loop control
- busy_o  out  1  sequencer in RUN or HALT
- done_o  out  1  one-cycle pulse at program completion
- issue_count_o  out  CycleCountWidth  instructions accepted since start

Behaviour:
- Reset or clr_i:
  - state=IDLE, PC=0, issue_count=0.
  - All outputs 0 except loop_clr_o=1 (for that cycle).
  - clr_i has priority over every other input.
- States:
  - IDLE: start_i → RUN; PC=0, count=0, loop_clr_o=1 for that cycle.
  - RUN: dbg_en_i=1 → HALT (evaluated before issue; no beat accepted that cycle).
  - HALT: dbg_en_i=0 → RUN.
  - DONE: returns to IDLE next cycle; done_o=1 only during the DONE cycle.
- inst_valid_o:
  - 1 in RUN.
  - 1 in HALT only during the cycle dbg_step_i is high; back-to-back steps allowed.
  - 0 in IDLE and DONE.
- Accept: accept = inst_valid_o & inst_ready_i.
- loop_en_o = busy_o. loop_stall_o = inst_valid_o & ~inst_ready_i, and 1 while halted and not stepping. Loop counters therefore advance only on accept.
- On accept, PC update in priority order:
  1. inst_jump_i → PC = inst_jump_addr_i.
  2. inst_loop_done_i (mode≠0) → DONE.
  3. mode==0 and PC==inst_last_addr_i → DONE.
  4. Otherwise PC+1.
- PC wraps modulo 2^InstMemAddrWidth; no error is flagged.
- No accept → PC holds; inst_jump_i and inst_loop_done_i are ignored.
- Jump and done on the same beat: jump wins. This is legal only with a misconfigured loop block.
- issue_count increments on each accept and saturates at all-ones. It holds after DONE until the next start_i.
- start_i while busy or in DONE is ignored.
- dbg_step_i outside HALT is ignored.
- Latency: PC changes the cycle after accept; done_o asserts the cycle after the final accept.
- Reset mid-run: immediate abort, no done_o.

Decomposition:
- Shared package hypercorex_pkg gets:
  - state enum seq_state_e {IDLE, RUN, HALT, DONE}
  - constant LoopDisable = 0
- Sub-module: none required.
- The saturating counter may be a small generic instance, sat_counter, reusable elsewhere.

Test Plan:
- Loops disabled, inst_last_addr_i=3, ready=1, start: PC 0,1,2,3 with 4 accepts → done_o pulse 1 cycle later, issue_count=4, IDLE.
- Backpressure: ready low 3 cycles at PC=2 → PC holds 2, loop_stall_o=1 for those cycles, count unchanged; resumes at 3.
- Loop emulation: jump(target 1) asserted when PC=3 for the first two accepts at 3, then loop_done at 3 → PC sequence 0,1,2,3,1,2,3,1,2,3 then DONE, count=10.
- Debug: dbg_en_i at PC=5 → valid=0; three dbg_step_i pulses → PC 6,7,8; release dbg_en_i → RUN continues from 8.
- Clear/reset mid-run at PC=7 → next cycle IDLE, PC=0, loop_clr_o=1, no done_o; start_i then restarts at 0.
- Ignored inputs: start_i while RUN and dbg_step_i while RUN → no PC disturbance; jump and done together → jump taken.

Source files
------------

// File: rtl/hypercorex_pkg.sv
// hypercorex_pkg: shared types and constants for the instruction sequencer.
package hypercorex_pkg;

    typedef enum logic [1:0] {IDLE, RUN, HALT, DONE} seq_state_e;

    // Loop mode value meaning "no hardware loops; stop at the last address".
    localparam int unsigned LoopDisable = 0;

endpackage

// File: rtl/inst_seq_ctrl_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned Width = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] r_count;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) r_count <= '0;
        else if (inc_i && !(&r_count)) r_count <= r_count + Width'(1);
    end

    assign count_o = r_count;

endmodule

// File: rtl/inst_seq_ctrl.sv
// inst_seq_ctrl: program-counter sequencer issuing one instruction per accepted beat.
module inst_seq_ctrl
    import hypercorex_pkg::*;
#(
    parameter int unsigned InstMemAddrWidth = 32,
    parameter int unsigned CycleCountWidth  = 32,
    parameter int unsigned LoopNumWidth     = 3
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic                        clr_i,
    input  logic                        dbg_en_i,
    input  logic                        dbg_step_i,
    input  logic [LoopNumWidth-1:0]     inst_loop_mode_i,
    input  logic [InstMemAddrWidth-1:0] inst_last_addr_i,
    input  logic                        inst_jump_i,
    input  logic [InstMemAddrWidth-1:0] inst_jump_addr_i,
    input  logic                        inst_loop_done_i,
    input  logic                        inst_ready_i,
    output logic [InstMemAddrWidth-1:0] inst_pc_o,
    output logic                        inst_valid_o,
    output logic                        loop_en_o,
    output logic                        loop_stall_o,
    output logic                        loop_clr_o,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [CycleCountWidth-1:0]  issue_count_o
);

    seq_state_e                  r_state;
    logic [InstMemAddrWidth-1:0] r_pc;
    logic                        r_loop_clr;

    logic w_run, w_halt, w_start, w_accept, w_loops_on, w_finish;

    assign w_run      = r_state == RUN;
    assign w_halt     = r_state == HALT;
    assign w_start    = (r_state == IDLE) && start_i;
    assign w_loops_on = inst_loop_mode_i != LoopNumWidth'(LoopDisable);
    // A jump on the same beat always wins over program completion.
    assign w_finish   = !inst_jump_i &&
                        (w_loops_on ? inst_loop_done_i : r_pc == inst_last_addr_i);

    // A debug halt request blocks issue in the same cycle it is raised.
    assign inst_valid_o = (w_run && !dbg_en_i) || (w_halt && dbg_step_i);
    assign w_accept     = inst_valid_o && inst_ready_i;

    assign busy_o       = w_run || w_halt;
    assign loop_en_o    = busy_o;
    assign loop_stall_o = busy_o && !w_accept;
    assign loop_clr_o   = r_loop_clr || w_start;
    assign done_o       = r_state == DONE;
    assign inst_pc_o    = r_pc;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_state    <= IDLE;
            r_pc       <= '0;
            r_loop_clr <= 1'b1;
        end else begin
            r_loop_clr <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_state <= RUN;
                        r_pc    <= '0;
                    end
                end
                RUN, HALT: begin
                    if (w_accept)
                        r_pc <= inst_jump_i ? inst_jump_addr_i :
                                w_finish    ? r_pc : r_pc + InstMemAddrWidth'(1);
                    if (w_accept && w_finish) r_state <= DONE;
                    else if (w_run && dbg_en_i) r_state <= HALT;
                    else if (w_halt && !dbg_en_i) r_state <= RUN;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    sat_counter #(
        .Width(CycleCountWidth)
    ) i_issue_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (clr_i || w_start),
        .inc_i  (w_accept),
        .count_o(issue_count_o)
    );

endmodule

// File: tb/tb_inst_seq_ctrl.sv
// tb_inst_seq_ctrl: directed table and sequence checks for the instruction sequencer.
module tb_inst_seq_ctrl;

    localparam int AW = 32;
    localparam int CW = 4;
    localparam int LW = 3;

    logic          clk = 1'b0;
    logic          rst, start, clr, dbg_en, dbg_step, jump, ldone, ready;
    logic [LW-1:0] mode;
    logic [AW-1:0] last, jaddr, pc;
    logic          valid, len, lstall, lclr, busy, done;
    logic [CW-1:0] cnt;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    inst_seq_ctrl #(
        .InstMemAddrWidth(AW),
        .CycleCountWidth (CW),
        .LoopNumWidth    (LW)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .start_i         (start),
        .clr_i           (clr),
        .dbg_en_i        (dbg_en),
        .dbg_step_i      (dbg_step),
        .inst_loop_mode_i(mode),
        .inst_last_addr_i(last),
        .inst_jump_i     (jump),
        .inst_jump_addr_i(jaddr),
        .inst_loop_done_i(ldone),
        .inst_ready_i    (ready),
        .inst_pc_o       (pc),
        .inst_valid_o    (valid),
        .loop_en_o       (len),
        .loop_stall_o    (lstall),
        .loop_clr_o      (lclr),
        .busy_o          (busy),
        .done_o          (done),
        .issue_count_o   (cnt)
    );

    // in = {start, dbg_en, dbg_step, jump, loop_done, ready}; fl = {valid, stall, busy, done, loop_clr}
    typedef struct {
        logic [5:0] in;
        logic [7:0] pc;
        logic [4:0] fl;
        logic [3:0] cnt;
    } vec_t;

    vec_t tbl[11];
    int   seq[10] = '{0, 1, 2, 3, 1, 2, 3, 1, 2, 3};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic d, input logic st, input logic j,
                         input logic ld, input logic r, input logic [AW-1:0] ja);
        start = s; dbg_en = d; dbg_step = st; jump = j; ldone = ld; ready = r; jaddr = ja;
        #1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; mode = '0; last = 32'd3;
        drive(0, 0, 0, 0, 0, 0, '0);
        cyc();
        cyc();
        rst = 1'b0;

        // Loops disabled, last=3, with a 3-cycle backpressure window at PC=2.
        tbl[0]  = '{6'b000000, 8'd0, 5'b00001, 4'd0};
        tbl[1]  = '{6'b100000, 8'd0, 5'b00001, 4'd0};
        tbl[2]  = '{6'b000001, 8'd0, 5'b10100, 4'd0};
        tbl[3]  = '{6'b000001, 8'd1, 5'b10100, 4'd1};
        tbl[4]  = '{6'b000000, 8'd2, 5'b11100, 4'd2};
        tbl[5]  = '{6'b000000, 8'd2, 5'b11100, 4'd2};
        tbl[6]  = '{6'b000000, 8'd2, 5'b11100, 4'd2};
        tbl[7]  = '{6'b000001, 8'd2, 5'b10100, 4'd2};
        tbl[8]  = '{6'b000001, 8'd3, 5'b10100, 4'd3};
        tbl[9]  = '{6'b100000, 8'd3, 5'b00010, 4'd4};
        tbl[10] = '{6'b000000, 8'd3, 5'b00000, 4'd4};
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].in[5], tbl[i].in[4], tbl[i].in[3], tbl[i].in[2],
                  tbl[i].in[1], tbl[i].in[0], '0);
            chk($sformatf("v%0d_pc", i), pc, {24'd0, tbl[i].pc});
            chk($sformatf("v%0d_flags", i), {valid, lstall, busy, done, lclr}, {27'd0, tbl[i].fl});
            chk($sformatf("v%0d_loop_en", i), len, tbl[i].fl[2]);
            chk($sformatf("v%0d_cnt", i), cnt, tbl[i].cnt);
            cyc();
        end

        // Loop emulation: two jumps back to 1 at PC=3, then loop_done at PC=3.
        mode = 3'd1;
        drive(1, 0, 0, 0, 0, 0, '0);
        cyc();
        begin
            int nj = 0;
            for (int i = 0; i < 10; i++) begin
                drive(0, 0, 0, seq[i] == 3 && nj < 2, seq[i] == 3 && nj == 2, 1, 32'd1);
                chk($sformatf("loop%0d_pc", i), pc, seq[i]);
                if (seq[i] == 3 && nj < 2) nj++;
                cyc();
            end
        end
        drive(0, 0, 0, 0, 0, 0, '0);
        chk("loop_done", done, 1'b1);
        chk("loop_cnt", cnt, 4'd10);
        chk("loop_busy", busy, 1'b0);
        cyc();
        chk("loop_done_pulse", done, 1'b0);

        // Debug halt at PC=5, three single steps, then resume.
        mode = '0; last = 32'd100;
        drive(1, 0, 0, 0, 0, 0, '0);
        cyc();
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 0, 0, 1, '0);
            cyc();
        end
        drive(0, 1, 0, 0, 0, 1, '0);
        chk("dbg_req_valid", valid, 1'b0);
        chk("dbg_req_stall", lstall, 1'b1);
        chk("dbg_req_pc", pc, 32'd5);
        cyc();
        drive(0, 1, 0, 0, 0, 1, '0);
        chk("halt_valid", valid, 1'b0);
        chk("halt_stall", lstall, 1'b1);
        chk("halt_busy", busy, 1'b1);
        cyc();
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 1, 0, 0, 1, '0);
            chk($sformatf("step%0d_pc", k), pc, 5 + k);
            chk($sformatf("step%0d_valid", k), valid, 1'b1);
            chk($sformatf("step%0d_stall", k), lstall, 1'b0);
            cyc();
        end
        drive(0, 1, 0, 0, 0, 1, '0);
        chk("post_step_pc", pc, 32'd8);
        cyc();
        drive(0, 0, 0, 0, 0, 1, '0);
        chk("release_valid", valid, 1'b0);
        cyc();
        drive(0, 0, 0, 0, 0, 1, '0);
        chk("resume_pc", pc, 32'd8);
        chk("resume_valid", valid, 1'b1);
        cyc();

        // Ignored step/start while running, jump+done together, PC wrap, count saturation.
        drive(0, 0, 1, 0, 0, 1, '0);
        chk("ign_step_pc", pc, 32'd9);
        cyc();
        drive(1, 0, 0, 0, 0, 1, '0);
        chk("ign_start_pc", pc, 32'd10);
        chk("ign_start_clr", lclr, 1'b0);
        cyc();
        mode = 3'd1;
        drive(0, 0, 0, 1, 1, 1, 32'hFFFF_FFFF);
        chk("jd_pc", pc, 32'd11);
        cyc();
        drive(0, 0, 0, 0, 0, 1, '0);
        chk("jump_wins_pc", pc, 32'hFFFF_FFFF);
        chk("jump_wins_busy", busy, 1'b1);
        chk("jump_wins_cnt", cnt, 4'd12);
        cyc();
        drive(0, 0, 0, 0, 0, 1, '0);
        chk("wrap_pc", pc, 32'd0);
        cyc();
        drive(0, 0, 0, 0, 0, 1, '0);
        chk("cnt14", cnt, 4'd14);
        cyc();
        drive(0, 0, 0, 0, 0, 1, '0);
        cyc();
        drive(0, 0, 0, 0, 0, 1, '0);
        chk("sat_pc", pc, 32'd3);
        chk("sat_cnt", cnt, 4'd15);
        for (int i = 0; i < 4; i++) cyc();

        // Clear mid-run at PC=7, then restart.
        chk("pre_clr_pc", pc, 32'd7);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        drive(0, 0, 0, 0, 0, 1, '0);
        chk("clr_busy", busy, 1'b0);
        chk("clr_pc", pc, 32'd0);
        chk("clr_lclr", lclr, 1'b1);
        chk("clr_done", done, 1'b0);
        chk("clr_valid", valid, 1'b0);
        chk("clr_cnt", cnt, 4'd0);
        cyc();
        chk("clr_no_done", done, 1'b0);
        chk("clr_lclr_drop", lclr, 1'b0);
        drive(1, 0, 0, 0, 0, 1, '0);
        cyc();
        drive(0, 0, 0, 0, 0, 1, '0);
        chk("restart_pc", pc, 32'd0);
        chk("restart_valid", valid, 1'b1);
        cyc();
        chk("restart_pc1", pc, 32'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
